// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode, state and helper definitions for the EX-stage ALU sequencer
//
// Purpose : Shared constants for alu_seq_ctrl and its helpers.
//           - ALUCtrl opcode encodings
//           - FSM state encoding
//           - BITS_PER_CYCLE legality check
//           - single-cycle ALU evaluation function
// Ports   : none (package)
// Options : MUL_EARLY_EXIT_EN is consumed by alu_seq_ctrl, not here.

package alu_pkg;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_XOR  = 4'b0001;
  localparam logic [3:0] OP_SLL  = 4'b0010;
  localparam logic [3:0] OP_ADD  = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0100;
  localparam logic [3:0] OP_MUL  = 4'b0101;
  localparam logic [3:0] OP_ADDI = 4'b0110;
  localparam logic [3:0] OP_SRAI = 4'b0111;
  localparam logic [3:0] OP_LSW  = 4'b1000;
  localparam logic [3:0] OP_BEQ  = 4'b1001;
  localparam logic [3:0] OP_OR   = 4'b1010;
  localparam logic [3:0] OP_NOOP = 4'b1011;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    MUL_RUN = 2'b01
  } state_e;

  // Legal multiplier step widths; each must divide 32 evenly.
  localparam int unsigned BPC_LEGAL_1 = 1;
  localparam int unsigned BPC_LEGAL_2 = 2;
  localparam int unsigned BPC_LEGAL_4 = 4;
  localparam int unsigned BPC_LEGAL_8 = 8;

  function automatic bit bpc_is_legal(input int unsigned bpc);
    return (bpc == BPC_LEGAL_1) || (bpc == BPC_LEGAL_2) ||
           (bpc == BPC_LEGAL_4) || (bpc == BPC_LEGAL_8);
  endfunction

  // Result of every single-cycle opcode. MUL never reaches here; BEQ, NoOp
  // and the unused 1100-1111 codes all yield 0.
  function automatic logic [31:0] alu_eval(input logic [3:0]  op,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
    logic [31:0] r;
    case (op)
      OP_AND:                  r = a & b;
      OP_XOR:                  r = a ^ b;
      OP_OR:                   r = a | b;
      OP_SLL:                  r = a << b[4:0];
      OP_SRAI:                 r = $unsigned($signed(a) >>> b[4:0]);
      OP_ADD, OP_ADDI, OP_LSW: r = a + b;
      OP_SUB:                  r = a - b;
      default:                 r = 32'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_seq_ctrl_if.sv
// rtl/alu_seq_ctrl_if.sv - operation/result bundle between ID/EX and the ALU sequencer
//
// Purpose : Groups the request and result signals of alu_seq_ctrl.
// Signals : valid_i/ready_o/flush_i/ALUCtrl_i/data1_i/data2_i - request side
//           valid_o/data_o/Zero_o/busy_o                     - result side
// Modports: slave  - the ALU sequencer
//           master - the pipeline driving it

interface alu_seq_ctrl_if;

  logic        valid_i;
  logic        ready_o;
  logic        flush_i;
  logic [3:0]  ALUCtrl_i;
  logic [31:0] data1_i;
  logic [31:0] data2_i;
  logic        valid_o;
  logic [31:0] data_o;
  logic        Zero_o;
  logic        busy_o;

  modport slave (
    input  valid_i, flush_i, ALUCtrl_i, data1_i, data2_i,
    output ready_o, valid_o, data_o, Zero_o, busy_o
  );

  modport master (
    output valid_i, flush_i, ALUCtrl_i, data1_i, data2_i,
    input  ready_o, valid_o, data_o, Zero_o, busy_o
  );

endinterface

// File: rtl/alu_mul_step.sv
// rtl/alu_mul_step.sv - one combinational shift-add step of the iterative multiplier
//
// Purpose : Retires BPC multiplier bits: adds the partial product to the
//           accumulator, shifts the multiplicand left and the multiplier right.
// Ports   : mcand_i  - current multiplicand (already pre-shifted)
//           mplier_i - remaining multiplier bits
//           acc_i    - running accumulator
//           acc_o    - accumulator after this step
//           mcand_o  - multiplicand for the next step
//           mplier_o - multiplier for the next step

module alu_mul_step #(
  parameter int unsigned BPC   = 1,
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] mcand_i,
  input  logic [WIDTH-1:0] mplier_i,
  input  logic [WIDTH-1:0] acc_i,
  output logic [WIDTH-1:0] acc_o,
  output logic [WIDTH-1:0] mcand_o,
  output logic [WIDTH-1:0] mplier_o
);

  logic [WIDTH-1:0] pp;

  // Partial product mcand * mplier[BPC-1:0] built as a sum of shifted copies;
  // everything is truncated to WIDTH, which keeps the low half exact.
  always_comb begin
    pp = '0;
    for (int i = 0; i < BPC; i++) begin
      if (mplier_i[i]) begin
        pp = pp + (mcand_i << i);
      end
    end
    acc_o    = acc_i + pp;
    mcand_o  = mcand_i << BPC;
    mplier_o = mplier_i >> BPC;
  end

endmodule

// File: rtl/alu_seq_ctrl.sv
// rtl/alu_seq_ctrl.sv - registered EX-stage ALU front-end with iterative MUL sequencer
//
// Purpose : Single-cycle ALU ops return one cycle after acceptance; MUL runs
//           as WIDTH/BITS_PER_CYCLE shift-add steps with busy_o stalling the
//           pipeline. flush_i aborts an in-flight MUL or drops an offered op.
// Ports   : clk_i - clock, rising edge
//           rst_i - asynchronous active-high reset
//           bus   - alu_seq_ctrl_if.slave (request/result bundle)
// Options : MUL_EARLY_EXIT_EN - finish MUL as soon as the remaining
//           multiplier is zero (result unchanged, latency data dependent).

module alu_seq_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned BITS_PER_CYCLE = 1,
  parameter int unsigned WIDTH          = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  alu_seq_ctrl_if.slave bus
);

  // Illegal step widths fall back to one bit per cycle.
  localparam int unsigned BPC  = bpc_is_legal(BITS_PER_CYCLE) ? BITS_PER_CYCLE : 1;
  localparam int unsigned N    = WIDTH / BPC;
  localparam logic [4:0]  LAST = 5'(N - 1);

  state_e      state_q, state_d;
  logic [31:0] mcand_q, mcand_d;
  logic [31:0] mplier_q, mplier_d;
  logic [31:0] acc_q, acc_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] data_q, data_d;
  logic        zero_q, zero_d;
  logic        valid_q, valid_d;

  logic [31:0] step_acc, step_mcand, step_mplier;
  logic [31:0] alu_res;
  logic        mul_done;

  alu_mul_step #(
    .BPC   (BPC),
    .WIDTH (32)
  ) u_mul_step (
    .mcand_i  (mcand_q),
    .mplier_i (mplier_q),
    .acc_i    (acc_q),
    .acc_o    (step_acc),
    .mcand_o  (step_mcand),
    .mplier_o (step_mplier)
  );

  assign alu_res = alu_eval(bus.ALUCtrl_i, bus.data1_i, bus.data2_i);

`ifdef MUL_EARLY_EXIT_EN
  // No multiplier bits left means every later step would add zero.
  assign mul_done = (cnt_q == LAST) || (step_mplier == 32'd0);
`else
  assign mul_done = (cnt_q == LAST);
`endif

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    zero_d   = zero_q;
    valid_d  = 1'b0;

    case (state_q)
      IDLE: begin
        // flush_i beats valid_i: the offered op is simply dropped.
        if (bus.valid_i && !bus.flush_i) begin
          if (bus.ALUCtrl_i == OP_MUL) begin
            mcand_d  = bus.data1_i;
            mplier_d = bus.data2_i;
            acc_d    = 32'd0;
            cnt_d    = 5'd0;
            state_d  = MUL_RUN;
          end else begin
            data_d  = alu_res;
            zero_d  = (alu_res == 32'd0);
            valid_d = 1'b1;
          end
        end
      end

      MUL_RUN: begin
        if (bus.flush_i) begin
          state_d = IDLE;
        end else begin
          mcand_d  = step_mcand;
          mplier_d = step_mplier;
          acc_d    = step_acc;
          cnt_d    = cnt_q + 5'd1;
          if (mul_done) begin
            data_d  = step_acc;
            zero_d  = (step_acc == 32'd0);
            valid_d = 1'b1;
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      mcand_q  <= 32'd0;
      mplier_q <= 32'd0;
      acc_q    <= 32'd0;
      cnt_q    <= 5'd0;
      data_q   <= 32'd0;
      zero_q   <= 1'b1;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      zero_q   <= zero_d;
      valid_q  <= valid_d;
    end
  end

  assign bus.ready_o = (state_q == IDLE);
  assign bus.busy_o  = (state_q == MUL_RUN);
  assign bus.valid_o = valid_q;
  assign bus.data_o  = data_q;
  assign bus.Zero_o  = zero_q;

endmodule
